// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned NIBBLE_W = 4;

  // Counter width for WIDTH/NIBBLE_W nibbles; at least one bit.
  function automatic int unsigned cnt_w(input int unsigned width);
    int unsigned n;
    n = width / NIBBLE_W;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_slice.sv
// 4-bit borrow-lookahead subtractor slice: d = a - b - bin, purely combinational.
module borrow_lookahead_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       bin_i,
  output logic [3:0] d_o,
  output logic       bout_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] brw;

  always_comb begin
    g = ~a_i & b_i;
    p = ~(a_i ^ b_i);
    // Each borrow is expanded directly from G/P and bin, not rippled.
    brw[0] = bin_i;
    brw[1] = g[0] | (p[0] & bin_i);
    brw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin_i);
    brw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & bin_i);
    brw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin_i);
    d_o    = a_i ^ b_i ^ brw[3:0];
    bout_o = brw[4];
  end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one nibble per clock, LSB first.
module nibble_serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / NIBBLE_W;
  localparam int unsigned CW = cnt_w(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_d;
  logic [CW-1:0]    cnt_q;
  logic             brw_q, brw_d;
  logic             busy_q, done_q, bout_q, ovf_q, zero_q;
  logic [3:0]       nib_a, nib_b, nib_d;
  logic             last_nib;

  borrow_lookahead_slice u_slice (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .bin_i  (brw_q),
    .d_o    (nib_d),
    .bout_o (brw_d)
  );

  always_comb begin
    nib_a    = a_q[int'(cnt_q)*NIBBLE_W +: NIBBLE_W];
    nib_b    = b_q[int'(cnt_q)*NIBBLE_W +: NIBBLE_W];
    diff_d   = diff_q;
    diff_d[int'(cnt_q)*NIBBLE_W +: NIBBLE_W] = nib_d;
    last_nib = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          diff_q <= diff_d;
          brw_q  <= brw_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_nib) begin
            bout_q  <= brw_d;
            ovf_q   <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_d[WIDTH-1] ^ a_q[WIDTH-1]);
            zero_q  <= (diff_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE otherwise falls back to IDLE.
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            brw_q   <= bin;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor (WIDTH=16).
module tb_nibble_serial_subtractor;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout, ovf, zero;
  logic [W-1:0] diff;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } res_t;

  res_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  int   done_gap = 0;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    res_t r;
    logic [W:0] t;
    t      = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    r.diff = t[W-1:0];
    r.bout = t[W];
    r.ovf  = (x[W-1] ^ y[W-1]) & (t[W-1] ^ x[W-1]);
    r.zero = (t[W-1:0] == '0);
    return r;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst && done) begin
      res_t e;
      done_cnt++;
      done_gap      = cyc - last_done_cyc;
      last_done_cyc = cyc;
      check("busy_with_done", {63'd0, busy}, 64'd0);
      if (q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("diff", {48'd0, diff}, {48'd0, e.diff});
        check("bout", {63'd0, bout}, {63'd0, e.bout});
        check("ovf",  {63'd0, ovf},  {63'd0, e.ovf});
        check("zero", {63'd0, zero}, {63'd0, e.zero});
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input res_t e);
    @(negedge clk);
    a = x; b = y; bin = c; start = 1'b1;
    @(posedge clk);
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    res_t e;
    int   dc;
    logic [W-1:0] ra, rb;
    logic         rc;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_diff", {48'd0, diff}, 64'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors: {diff, bout, ovf, zero} computed by hand.
    issue(16'h1234, 16'h0034, 1'b0, {16'h1200, 1'b0, 1'b0, 1'b0}); wait_drain();
    issue(16'h0000, 16'h0001, 1'b0, {16'hFFFF, 1'b1, 1'b0, 1'b0}); wait_drain();
    issue(16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b1, 1'b0}); wait_drain();
    issue(16'h5555, 16'h5554, 1'b1, {16'h0000, 1'b0, 1'b0, 1'b1}); wait_drain();
    issue(16'h1000, 16'h0001, 1'b0, {16'h0FFF, 1'b0, 1'b0, 1'b0}); wait_drain();
    issue(16'h0000, 16'h0000, 1'b1, {16'hFFFF, 1'b1, 1'b0, 1'b0}); wait_drain();
    issue(16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 1'b1, 1'b1, 1'b0}); wait_drain();

    // Start re-pulsed with other operands during RUN must be ignored.
    dc = done_cnt;
    @(negedge clk);
    a = 16'hABCD; b = 16'h0BCD; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    q.push_back({16'hA000, 1'b0, 1'b0, 1'b0});
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 16'h0000; b = 16'hFFFF; bin = 1'b1; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    check("single_done", 64'(done_cnt - dc), 64'd1);

    // Asynchronous reset during RUN cycle 2 aborts without done.
    dc = done_cnt;
    @(negedge clk);
    a = 16'h4321; b = 16'h1234; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_diff", {48'd0, diff}, 64'd0);
    check("abort_flags", {61'd0, bout, ovf, zero}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - dc), 64'd0);
    issue(16'h4321, 16'h1234, 1'b0, {16'h30ED, 1'b0, 1'b0, 1'b0}); wait_drain();

    // Back-to-back: start held through DONE, second accept on edge ending DONE.
    @(negedge clk);
    a = 16'h00FF; b = 16'h0100; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    q.push_back({16'hFFFF, 1'b1, 1'b0, 1'b0});
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b2b_first_done_seen", {63'd0, done}, 64'd1);
    end
    a = 16'h9000; b = 16'h1000; bin = 1'b1;
    @(posedge clk);
    q.push_back({16'h7FFF, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    check("b2b_gap", 64'(done_gap), 64'd5);

    // Random operands against the arithmetic reference model.
    for (int unsigned i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(1));
      e  = model(ra, rb, rc);
      issue(ra, rb, rc, e);
      wait_drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete, errors %0d", errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
